// File: rtl/monitor_motor.sv
// Coil-pattern monitor for a 4-phase half-step stepper: decodes the coil bus,
// tracks position modulo one revolution, direction, motion and sequencing faults.
module monitor_motor #(
  parameter int PASOS_VUELTA  = 4096,
  parameter int POS_W         = 16,
  parameter int QUIETO_CICLOS = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       M,
  input  logic             borrar,
  output logic [POS_W-1:0] posicion,
  output logic             sentido,
  output logic             paso,
  output logic             en_movimiento,
  output logic             error,
  output logic [7:0]       cont_errores
);

  localparam int QW = $clog2(QUIETO_CICLOS + 1);
  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(PASOS_VUELTA - 1);
  localparam logic [QW-1:0]    QUIET_LOAD = QW'(QUIETO_CICLOS);

  typedef enum logic {INICIO, SEGUIMIENTO} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0]       r_mSync1;
  logic [3:0]       r_mSync2;
  logic [3:0]       r_mPrev;
  logic [2:0]       r_ult;
  logic [POS_W-1:0] r_pos;
  logic             r_sentido;
  logic             r_paso;
  logic             r_error;
  logic [7:0]       r_cont;
  logic [QW-1:0]    r_quiet;

  logic       w_valid;
  logic       w_off;
  logic [2:0] w_idx;
  logic [2:0] w_delta;
  logic       w_chg;
  logic       w_fwd;
  logic       w_rev;
  logic       w_fault;
  logic       w_loadUlt;
  logic       w_step;

  // Two-flop synchronizer; r_mPrev lets a held pattern produce no repeated events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mSync1 <= 4'b0000;
      r_mSync2 <= 4'b0000;
      r_mPrev  <= 4'b0000;
    end else begin
      r_mSync1 <= M;
      r_mSync2 <= r_mSync1;
      r_mPrev  <= r_mSync2;
    end
  end

  always_comb begin
    w_valid = 1'b1;
    w_off   = 1'b0;
    w_idx   = 3'd0;
    case (r_mSync2)
      4'b0001: w_idx = 3'd0;
      4'b0011: w_idx = 3'd1;
      4'b0010: w_idx = 3'd2;
      4'b0110: w_idx = 3'd3;
      4'b0100: w_idx = 3'd4;
      4'b1100: w_idx = 3'd5;
      4'b1000: w_idx = 3'd6;
      4'b1001: w_idx = 3'd7;
      4'b0000: begin
        w_valid = 1'b0;
        w_off   = 1'b1;
      end
      default: w_valid = 1'b0;
    endcase
  end

  assign w_delta = w_idx - r_ult;
  assign w_chg   = (r_mSync2 != r_mPrev);
  assign w_step  = w_fwd | w_rev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= INICIO;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_chg) begin
      case (r_state)
        INICIO:      if (w_valid)  w_nextState = SEGUIMIENTO;
        SEGUIMIENTO: if (!w_valid) w_nextState = INICIO;
        default:     w_nextState = INICIO;
      endcase
    end
  end

  // Step and fault strobes are only evaluated when the synchronized pattern changes.
  always_comb begin
    w_fwd     = 1'b0;
    w_rev     = 1'b0;
    w_fault   = 1'b0;
    w_loadUlt = 1'b0;
    if (w_chg) begin
      if (w_valid) begin
        w_loadUlt = 1'b1;
        if (r_state == SEGUIMIENTO) begin
          case (w_delta)
            3'd0:    ;
            3'd1:    w_fwd   = 1'b1;
            3'd7:    w_rev   = 1'b1;
            default: w_fault = 1'b1;
          endcase
        end
      end else if (!w_off) begin
        w_fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ult     <= 3'd0;
      r_sentido <= 1'b1;
      r_paso    <= 1'b0;
    end else begin
      r_paso <= w_step;
      if (w_loadUlt) r_ult <= w_idx;
      if (w_fwd)      r_sentido <= 1'b1;
      else if (w_rev) r_sentido <= 1'b0;
    end
  end

  // A clear request overrides any step or fault landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos   <= '0;
      r_error <= 1'b0;
      r_cont  <= 8'd0;
    end else if (borrar) begin
      r_pos   <= '0;
      r_error <= 1'b0;
      r_cont  <= 8'd0;
    end else begin
      if (w_fwd)      r_pos <= (r_pos == POS_MAX) ? '0 : r_pos + POS_W'(1);
      else if (w_rev) r_pos <= (r_pos == '0) ? POS_MAX : r_pos - POS_W'(1);
      if (w_fault) begin
        r_error <= 1'b1;
        if (r_cont != 8'd255) r_cont <= r_cont + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_quiet <= '0;
    else if (w_step)        r_quiet <= QUIET_LOAD;
    else if (r_quiet != '0) r_quiet <= r_quiet - QW'(1);
  end

  assign posicion      = r_pos;
  assign sentido       = r_sentido;
  assign paso          = r_paso;
  assign en_movimiento = (r_quiet != '0);
  assign error         = r_error;
  assign cont_errores  = r_cont;

endmodule

// File: tb/tb_monitor_motor.sv
// Randomized and directed bench for monitor_motor, checked every cycle against
// a behavioural position/fault model.
module tb_monitor_motor;

  localparam int PV = 4096;
  localparam int Q  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M;
  logic        borrar;
  logic [15:0] posicion;
  logic        sentido;
  logic        paso;
  logic        en_movimiento;
  logic        error;
  logic [7:0]  cont_errores;

  monitor_motor #(.PASOS_VUELTA(PV), .POS_W(16), .QUIETO_CICLOS(Q)) dut (
    .clk(clk), .rst(rst), .M(M), .borrar(borrar),
    .posicion(posicion), .sentido(sentido), .paso(paso),
    .en_movimiento(en_movimiento), .error(error), .cont_errores(cont_errores)
  );

  always #5 clk = ~clk;

  logic [3:0] pat [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  int nVec  = 0;
  int nFail = 0;
  int pasoCount = 0;

  // Model state: pattern pipeline mirrors the two sampling edges before evaluation.
  logic [3:0] pipeQ [$];
  logic [3:0] mCur;
  logic [3:0] mLastSeen;
  bit  mArmed;
  int  mUlt, mIdx, mD;
  int  mPos, mCont, mSince;
  bit  mSentido, mPaso, mError;
  bit  stepF, stepR, fault;

  function automatic int phaseOf(input logic [3:0] p);
    if (p == 4'b0000) return -2;
    for (int i = 0; i < 8; i++) if (pat[i] == p) return i;
    return -1;
  endfunction

  task automatic modelReset();
    pipeQ.delete();
    pipeQ.push_back(4'b0000);
    pipeQ.push_back(4'b0000);
    mLastSeen = 4'b0000;
    mArmed = 1'b0;
    mUlt = 0;
    mPos = 0;
    mSentido = 1'b1;
    mPaso = 1'b0;
    mError = 1'b0;
    mCont = 0;
    mSince = Q;
  endtask

  task automatic modelStep();
    stepF = 1'b0;
    stepR = 1'b0;
    fault = 1'b0;
    pipeQ.push_back(M);
    mCur = pipeQ.pop_front();
    if (mCur != mLastSeen) begin
      mIdx = phaseOf(mCur);
      if (mIdx >= 0) begin
        if (mArmed) begin
          mD = (mIdx - mUlt + 8) % 8;
          if (mD == 1)      stepF = 1'b1;
          else if (mD == 7) stepR = 1'b1;
          else if (mD != 0) fault = 1'b1;
        end
        mArmed = 1'b1;
        mUlt = mIdx;
      end else begin
        if (mIdx == -1) fault = 1'b1;
        mArmed = 1'b0;
      end
    end
    mLastSeen = mCur;
    mPaso = stepF | stepR;
    if (stepF) begin
      mPos = (mPos + 1) % PV;
      mSentido = 1'b1;
    end
    if (stepR) begin
      mPos = (mPos + PV - 1) % PV;
      mSentido = 1'b0;
    end
    if (fault) begin
      mError = 1'b1;
      if (mCont < 255) mCont++;
    end
    if (borrar) begin
      mPos = 0;
      mError = 1'b0;
      mCont = 0;
    end
    if (mPaso) mSince = 0;
    else if (mSince < Q) mSince++;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelReset();
      else     modelStep();
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (paso) pasoCount++;
      checkOutput("posicion", int'(posicion), mPos);
      checkOutput("sentido", int'(sentido), int'(mSentido));
      checkOutput("paso", int'(paso), int'(mPaso));
      checkOutput("en_movimiento", int'(en_movimiento), int'(mSince < Q));
      checkOutput("error", int'(error), int'(mError));
      checkOutput("cont_errores", int'(cont_errores), mCont);
    end
  end

  task automatic applyStimulus(input logic [3:0] m, input logic b, input int n);
    @(negedge clk);
    M = m;
    borrar = b;
    repeat (n) begin
      @(negedge clk);
      borrar = 1'b0;
    end
  endtask

  int pc;
  int cnt;
  int drvIdx;
  int r;
  logic [3:0] nextM;

  initial begin
    rst = 1'b1;
    M = 4'b0000;
    borrar = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    applyStimulus(4'b0000, 1'b0, 20);
    checkOutput("rst_posicion", int'(posicion), 0);
    checkOutput("rst_sentido", int'(sentido), 1);
    checkOutput("rst_en_mov", int'(en_movimiento), 0);
    checkOutput("rst_error", int'(error), 0);
    checkOutput("rst_cont", int'(cont_errores), 0);
    checkOutput("rst_no_paso", pasoCount, 0);

    for (int i = 0; i < 9; i++) applyStimulus(pat[i % 8], 1'b0, 5);
    checkOutput("fwd_pasos", pasoCount, 8);
    checkOutput("fwd_posicion", int'(posicion), 8);
    checkOutput("fwd_sentido", int'(sentido), 1);
    checkOutput("fwd_error", int'(error), 0);

    applyStimulus(pat[0], 1'b1, 5);
    applyStimulus(pat[7], 1'b0, 5);
    applyStimulus(pat[6], 1'b0, 5);
    checkOutput("rev_posicion", int'(posicion), 4094);
    checkOutput("rev_sentido", int'(sentido), 0);
    applyStimulus(pat[6], 1'b0, 10);
    checkOutput("rev_hold", int'(posicion), 4094);

    applyStimulus(pat[6], 1'b1, 5);
    for (int i = 1; i <= 4095; i++) applyStimulus(pat[(6 + i) % 8], 1'b0, 1);
    applyStimulus(pat[(6 + 4095) % 8], 1'b0, 3);
    checkOutput("wrap_4095", int'(posicion), 4095);
    applyStimulus(pat[6], 1'b0, 4);
    checkOutput("wrap_zero", int'(posicion), 0);

    applyStimulus(4'b0000, 1'b1, 5);
    applyStimulus(pat[0], 1'b0, 5);
    pc = pasoCount;
    applyStimulus(pat[2], 1'b0, 5);
    checkOutput("skip_error", int'(error), 1);
    checkOutput("skip_cont", int'(cont_errores), 1);
    checkOutput("skip_posicion", int'(posicion), 0);
    checkOutput("skip_no_paso", pasoCount, pc);
    applyStimulus(pat[3], 1'b0, 5);
    checkOutput("after_skip", int'(posicion), 1);
    applyStimulus(4'b0101, 1'b0, 5);
    checkOutput("illegal_cont", int'(cont_errores), 2);
    applyStimulus(pat[1], 1'b0, 5);
    checkOutput("rearm_no_count", int'(posicion), 1);
    applyStimulus(pat[2], 1'b0, 5);
    checkOutput("rearm_counts", int'(posicion), 2);

    for (int i = 0; i < 300; i++) applyStimulus((i % 2 == 1) ? 4'b1010 : 4'b0101, 1'b0, 1);
    applyStimulus(4'b1010, 1'b0, 4);
    checkOutput("sat_cont", int'(cont_errores), 255);
    checkOutput("sat_error", int'(error), 1);

    applyStimulus(pat[0], 1'b0, 5);
    pc = pasoCount;
    @(negedge clk);
    M = pat[1];
    @(negedge clk);
    @(negedge clk);
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    applyStimulus(pat[1], 1'b0, 5);
    checkOutput("clr_posicion", int'(posicion), 0);
    checkOutput("clr_error", int'(error), 0);
    checkOutput("clr_cont", int'(cont_errores), 0);
    checkOutput("clr_paso", pasoCount, pc + 1);

    applyStimulus(pat[1], 1'b0, 30);
    cnt = 0;
    @(negedge clk);
    M = pat[2];
    repeat (40) begin
      @(negedge clk);
      if (en_movimiento) cnt++;
    end
    checkOutput("quiet_len", cnt, 16);
    checkOutput("quiet_pos", int'(posicion), 1);

    applyStimulus(pat[3], 1'b0, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_en", int'(en_movimiento), 0);
    checkOutput("midrst_pos", int'(posicion), 0);
    @(negedge clk);
    rst = 1'b0;
    pc = pasoCount;
    applyStimulus(pat[3], 1'b0, 6);
    checkOutput("midrst_rearm", int'(posicion), 0);
    checkOutput("midrst_no_paso", pasoCount, pc);

    drvIdx = 3;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      nextM = M;
      if (r < 45) begin
        drvIdx = (drvIdx + 1) % 8;
        nextM = pat[drvIdx];
      end else if (r < 70) begin
        drvIdx = (drvIdx + 7) % 8;
        nextM = pat[drvIdx];
      end else if (r < 78) begin
        drvIdx = $urandom_range(7);
        nextM = pat[drvIdx];
      end else if (r < 88) begin
        nextM = 4'($urandom_range(15));
      end else if (r < 93) begin
        nextM = 4'b0000;
      end
      applyStimulus(nextM, ($urandom_range(99) < 4) ? 1'b1 : 1'b0, $urandom_range(3, 1));
    end
    applyStimulus(M, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
